// File: rtl/mmu_bus_arbiter_pkg.sv
// Shared types for the two-port memory-map bus arbiter: bus payload, access size,
// exception mask and the arbiter's state/port encodings.
package mmu_bus_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ARB_CNT_W = 3;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef struct packed {
        logic misaligned;
        logic unmapped;
    } mem_exception_mask_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_A = 1'b0,
        ARB_PORT_B = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wr_data;
        logic            wr_ena;
        mem_access_t     access;
    } arb_payload_t;

endpackage

// File: rtl/rr_picker2.sv
// Two-way request picker: round-robin against the last winner, or fixed priority
// to A when mode is set.
module rr_picker2
    import mmu_bus_arbiter_pkg::*;
(
    input  logic      req_a,
    input  logic      req_b,
    input  arb_port_t last,
    input  logic      mode,
    output logic      valid,
    output arb_port_t winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = ARB_PORT_A;
        if (req_a && req_b) begin
            winner = (mode || (last == ARB_PORT_B)) ? ARB_PORT_A : ARB_PORT_B;
        end else if (req_b) begin
            winner = ARB_PORT_B;
        end
    end

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Shares the single memory-map bus between requester A (core) and B (DMA/debug):
// one access per grant, MEM_LATENCY bus cycles, then a one-cycle ack to the winner.
module mmu_bus_arbiter
    import mmu_bus_arbiter_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned MEM_LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                a_req,
    input  logic [XLEN-1:0]     a_addr,
    input  logic [XLEN-1:0]     a_wr_data,
    input  logic                a_wr_ena,
    input  mem_access_t         a_access,
    output logic                a_ack,
    output logic [XLEN-1:0]     a_rd_data,
    output mem_exception_mask_t a_exception,
    input  logic                b_req,
    input  logic [XLEN-1:0]     b_addr,
    input  logic [XLEN-1:0]     b_wr_data,
    input  logic                b_wr_ena,
    input  mem_access_t         b_access,
    output logic                b_ack,
    output logic [XLEN-1:0]     b_rd_data,
    output mem_exception_mask_t b_exception,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wr_data,
    output logic                mem_wr_ena,
    output mem_access_t         mem_access,
    input  logic [XLEN-1:0]     mem_rd_data,
    input  mem_exception_mask_t mem_exception,
    output logic                busy,
    output logic                grant_b
);

    localparam logic [ARB_CNT_W-1:0] CNT_LAST   = ARB_CNT_W'(MEM_LATENCY - 1);
    localparam logic                 PRIO_FIXED = (PRIORITY_MODE != 0);

    arb_state_t           r_state,   w_state_nxt;
    logic [ARB_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    arb_port_t            r_rr_last, w_rr_last_nxt;
    arb_port_t            r_grant,   w_grant_nxt;

    logic         w_elig_a;
    logic         w_elig_b;
    logic         w_pick_valid;
    arb_port_t    w_pick_winner;
    arb_payload_t w_pay_a;
    arb_payload_t w_pay_b;
    arb_payload_t w_pay_sel;

    assign w_pay_a = '{addr: a_addr, wr_data: a_wr_data, wr_ena: a_wr_ena, access: a_access};
    assign w_pay_b = '{addr: b_addr, wr_data: b_wr_data, wr_ena: b_wr_ena, access: b_access};

    // The port just acked still shows a stale req in S_RESP; it must not win again.
    assign w_elig_a = a_req && !((r_state == S_RESP) && (r_grant == ARB_PORT_A));
    assign w_elig_b = b_req && !((r_state == S_RESP) && (r_grant == ARB_PORT_B));

    rr_picker2 u_picker (
        .req_a  (w_elig_a),
        .req_b  (w_elig_b),
        .last   (r_rr_last),
        .mode   (PRIO_FIXED),
        .valid  (w_pick_valid),
        .winner (w_pick_winner)
    );

    // State, counter, RR pointer and grant latch; all frozen while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rr_last <= ARB_PORT_B;
            r_grant   <= ARB_PORT_A;
        end else if (ena) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_grant   <= w_grant_nxt;
        end
    end

    // Next state: S_RESP re-arbitrates directly so back-to-back grants have no bubble.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rr_last_nxt = r_rr_last;
        w_grant_nxt   = r_grant;
        unique case (r_state)
            S_IDLE, S_RESP: begin
                if (r_state == S_RESP) begin
                    w_rr_last_nxt = r_grant;
                end
                if (w_pick_valid) begin
                    w_state_nxt = S_ACCESS;
                    w_grant_nxt = w_pick_winner;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + ARB_CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: bus payload muxed live from the granted port; ack and response pass-through in S_RESP.
    always_comb begin
        w_pay_sel   = (r_grant == ARB_PORT_B) ? w_pay_b : w_pay_a;
        busy        = (r_state != S_IDLE);
        grant_b     = (r_grant == ARB_PORT_B);
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        mem_access  = MEM_ACCESS_BYTE;
        a_ack       = 1'b0;
        a_rd_data   = '0;
        a_exception = '0;
        b_ack       = 1'b0;
        b_rd_data   = '0;
        b_exception = '0;
        if (r_state != S_IDLE) begin
            mem_addr    = w_pay_sel.addr;
            mem_wr_data = w_pay_sel.wr_data;
            mem_access  = w_pay_sel.access;
        end
        if ((r_state == S_ACCESS) && (r_cnt == '0)) begin
            mem_wr_ena = w_pay_sel.wr_ena;
        end
        if (r_state == S_RESP) begin
            if (r_grant == ARB_PORT_A) begin
                a_ack       = 1'b1;
                a_rd_data   = mem_rd_data;
                a_exception = mem_exception;
            end else begin
                b_ack       = 1'b1;
                b_rd_data   = mem_rd_data;
                b_exception = mem_exception;
            end
        end
    end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Randomized bench for mmu_bus_arbiter: a round-robin/latency-3 instance and a
// fixed-priority/latency-1 instance, each against a transaction-level model.
module tb_mmu_bus_arbiter;
    import mmu_bus_arbiter_pkg::*;

    localparam int NI     = 2;
    localparam int NCYC   = 3000;
    localparam int LAT_RR = 3;
    localparam int LAT_FP = 1;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    logic                req_i   [NI][2];
    logic [31:0]         addr_i  [NI][2];
    logic [31:0]         wdata_i [NI][2];
    logic                wr_i    [NI][2];
    mem_access_t         acc_i   [NI][2];
    logic                ack_o   [NI][2];
    logic [31:0]         rd_o    [NI][2];
    mem_exception_mask_t exc_o   [NI][2];

    logic [31:0]         mem_addr_o  [NI];
    logic [31:0]         mem_wdata_o [NI];
    logic                mem_wr_o    [NI];
    mem_access_t         mem_acc_o   [NI];
    logic [31:0]         mem_rd_i    [NI];
    mem_exception_mask_t mem_exc_i   [NI];
    logic                busy_o      [NI];
    logic                grant_b_o   [NI];

    // Bus-side memory (what the DUT really wrote) and the model's expected memory.
    logic [31:0] bmem    [NI][16];
    logic [31:0] ref_mem [NI][16];
    bit          bmem_ready = 1'b0;

    int lat  [NI] = '{LAT_RR, LAT_FP};
    int mode [NI] = '{0, 1};

    // Reference model: active transaction, its owner and the enabled-cycle it began.
    bit m_act   [NI];
    bit m_fresh [NI];
    int m_own   [NI];
    int m_start [NI];
    int m_rr    [NI];
    int e_cnt;

    bit done   [NI][2];
    bit outst  [NI][2];
    bit rst_seen;
    int stall_left;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(.PRIORITY_MODE(0), .MEM_LATENCY(LAT_RR)) u_dut_rr (
        .clk(clk), .rst(rst), .ena(ena),
        .a_req(req_i[0][0]), .a_addr(addr_i[0][0]), .a_wr_data(wdata_i[0][0]),
        .a_wr_ena(wr_i[0][0]), .a_access(acc_i[0][0]),
        .a_ack(ack_o[0][0]), .a_rd_data(rd_o[0][0]), .a_exception(exc_o[0][0]),
        .b_req(req_i[0][1]), .b_addr(addr_i[0][1]), .b_wr_data(wdata_i[0][1]),
        .b_wr_ena(wr_i[0][1]), .b_access(acc_i[0][1]),
        .b_ack(ack_o[0][1]), .b_rd_data(rd_o[0][1]), .b_exception(exc_o[0][1]),
        .mem_addr(mem_addr_o[0]), .mem_wr_data(mem_wdata_o[0]), .mem_wr_ena(mem_wr_o[0]),
        .mem_access(mem_acc_o[0]), .mem_rd_data(mem_rd_i[0]), .mem_exception(mem_exc_i[0]),
        .busy(busy_o[0]), .grant_b(grant_b_o[0])
    );

    mmu_bus_arbiter #(.PRIORITY_MODE(1), .MEM_LATENCY(LAT_FP)) u_dut_fp (
        .clk(clk), .rst(rst), .ena(ena),
        .a_req(req_i[1][0]), .a_addr(addr_i[1][0]), .a_wr_data(wdata_i[1][0]),
        .a_wr_ena(wr_i[1][0]), .a_access(acc_i[1][0]),
        .a_ack(ack_o[1][0]), .a_rd_data(rd_o[1][0]), .a_exception(exc_o[1][0]),
        .b_req(req_i[1][1]), .b_addr(addr_i[1][1]), .b_wr_data(wdata_i[1][1]),
        .b_wr_ena(wr_i[1][1]), .b_access(acc_i[1][1]),
        .b_ack(ack_o[1][1]), .b_rd_data(rd_o[1][1]), .b_exception(exc_o[1][1]),
        .mem_addr(mem_addr_o[1]), .mem_wr_data(mem_wdata_o[1]), .mem_wr_ena(mem_wr_o[1]),
        .mem_access(mem_acc_o[1]), .mem_rd_data(mem_rd_i[1]), .mem_exception(mem_exc_i[1]),
        .busy(busy_o[1]), .grant_b(grant_b_o[1])
    );

    function automatic bit is_mapped(input logic [31:0] a);
        return a[31:6] == 26'd0;
    endfunction

    function automatic logic [31:0] init_word(input int k, input int i);
        return 32'hA500_0000 ^ (32'(k) << 8) ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Memory responds combinationally; unmapped addresses raise the unmapped bit.
    always_comb begin
        for (int k = 0; k < NI; k++) begin
            if (is_mapped(mem_addr_o[k])) begin
                mem_rd_i[k]  = bmem[k][mem_addr_o[k][5:2]];
                mem_exc_i[k] = '{misaligned: 1'b0, unmapped: 1'b0};
            end else begin
                mem_rd_i[k]  = 32'd0;
                mem_exc_i[k] = '{misaligned: 1'b0, unmapped: 1'b1};
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!bmem_ready) begin
                for (int i = 0; i < 16; i++) bmem[k][i] = init_word(k, i);
            end else if (mem_wr_o[k] && is_mapped(mem_addr_o[k])) begin
                bmem[k][mem_addr_o[k][5:2]] = mem_wdata_o[k];
            end
        end
        bmem_ready = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic check_outputs(input int k, input int cyc);
        string       pfx;
        int          el;
        int          o;
        bit          resp;
        bit          accs;
        bit          ack_e;
        logic [31:0] exp_rd;
        logic [31:0] exp_exc;
        pfx  = $sformatf("inst%0d cyc%0d", k, cyc);
        el   = e_cnt - m_start[k];
        o    = m_own[k];
        resp = m_act[k] && (el == lat[k]);
        accs = m_act[k] && !resp;
        check_eq({pfx, " busy"}, {31'd0, busy_o[k]}, {31'd0, m_act[k]});
        if (m_act[k] || m_fresh[k])
            check_eq({pfx, " grant_b"}, {31'd0, grant_b_o[k]}, m_act[k] ? 32'(o) : 32'd0);
        if (m_act[k]) begin
            check_eq({pfx, " mem_addr"}, mem_addr_o[k], addr_i[k][o]);
            check_eq({pfx, " mem_wr_data"}, mem_wdata_o[k], wdata_i[k][o]);
            check_eq({pfx, " mem_access"}, {30'd0, mem_acc_o[k]}, {30'd0, acc_i[k][o]});
        end else if (m_fresh[k]) begin
            check_eq({pfx, " mem_addr_rst"}, mem_addr_o[k], 32'd0);
            check_eq({pfx, " mem_wr_data_rst"}, mem_wdata_o[k], 32'd0);
            check_eq({pfx, " mem_access_rst"}, {30'd0, mem_acc_o[k]}, {30'd0, MEM_ACCESS_BYTE});
        end
        check_eq({pfx, " mem_wr_ena"}, {31'd0, mem_wr_o[k]},
                 {31'd0, accs && (el == 0) && wr_i[k][o]});
        for (int p = 0; p < 2; p++) begin
            ack_e   = resp && (o == p);
            exp_rd  = 32'd0;
            exp_exc = 32'd0;
            if (ack_e) begin
                if (is_mapped(addr_i[k][p])) exp_rd = ref_mem[k][addr_i[k][p][5:2]];
                else exp_exc = 32'd1;
            end
            check_eq($sformatf("%s ack%0d", pfx, p), {31'd0, ack_o[k][p]}, {31'd0, ack_e});
            check_eq($sformatf("%s rd%0d", pfx, p), rd_o[k][p], exp_rd);
            check_eq($sformatf("%s exc%0d", pfx, p), {30'd0, exc_o[k][p]}, exp_exc);
        end
    endtask

    // One clock edge of the transaction model.
    task automatic model_step(input int k);
        bit resp;
        bit ea;
        bit eb;
        int wn;
        done[k][0] = 1'b0;
        done[k][1] = 1'b0;
        if (rst) begin
            m_act[k]   = 1'b0;
            m_fresh[k] = 1'b1;
            m_rr[k]    = 1;
            return;
        end
        if (!ena) return;
        resp = m_act[k] && ((e_cnt - m_start[k]) == lat[k]);
        if (m_act[k] && !resp) return;
        if (resp) begin
            done[k][m_own[k]] = 1'b1;
            m_rr[k] = m_own[k];
        end
        ea = req_i[k][0] && !(resp && m_own[k] == 0);
        eb = req_i[k][1] && !(resp && m_own[k] == 1);
        m_act[k] = ea || eb;
        if (m_act[k]) begin
            if (ea && eb) wn = (mode[k] == 1) ? 0 : 1 - m_rr[k];
            else wn = ea ? 0 : 1;
            m_own[k]   = wn;
            m_start[k] = e_cnt + 1;
            m_fresh[k] = 1'b0;
            if (wr_i[k][wn] && is_mapped(addr_i[k][wn]))
                ref_mem[k][addr_i[k][wn][5:2]] = wdata_i[k][wn];
        end
    endtask

    task automatic drive_inputs(input int cyc);
        int unsigned pct;
        pct = (cyc < 1000) ? 100 : (cyc < 2000) ? 25 : 70;
        rst = (cyc < 2) ? 1'b1 : ($urandom_range(0, 249) == 0);
        if (stall_left > 0) begin
            ena = 1'b0;
            stall_left--;
        end else if ($urandom_range(0, 29) == 0) begin
            ena = 1'b0;
            stall_left = int'($urandom_range(0, 4));
        end else begin
            ena = 1'b1;
        end
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (rst_seen || done[k][p]) begin
                    outst[k][p] = 1'b0;
                    req_i[k][p] = 1'b0;
                end
                if (!outst[k][p]) begin
                    if ($urandom_range(0, 99) < pct) begin
                        if ($urandom_range(0, 7) == 0)
                            addr_i[k][p] = 32'h100 | (32'($urandom_range(0, 15)) << 2);
                        else
                            addr_i[k][p] = 32'($urandom_range(0, 15)) << 2;
                        wdata_i[k][p] = $urandom;
                        wr_i[k][p]    = $urandom_range(0, 1) == 1;
                        acc_i[k][p]   = mem_access_t'($urandom_range(0, 2));
                        req_i[k][p]   = 1'b1;
                        outst[k][p]   = 1'b1;
                    end
                end else if (req_i[k][p] && m_act[k] && m_own[k] == p && $urandom_range(0, 7) == 0) begin
                    req_i[k][p] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        ena        = 1'b1;
        e_cnt      = 0;
        stall_left = 0;
        rst_seen   = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_act[k]   = 1'b0;
            m_fresh[k] = 1'b1;
            m_own[k]   = 0;
            m_start[k] = 0;
            m_rr[k]    = 1;
            for (int i = 0; i < 16; i++) ref_mem[k][i] = init_word(k, i);
            for (int p = 0; p < 2; p++) begin
                req_i[k][p]   = 1'b0;
                addr_i[k][p]  = 32'd0;
                wdata_i[k][p] = 32'd0;
                wr_i[k][p]    = 1'b0;
                acc_i[k][p]   = MEM_ACCESS_BYTE;
                done[k][p]    = 1'b0;
                outst[k][p]   = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) check_outputs(k, cyc);
            rst_seen = rst;
            for (int k = 0; k < NI; k++) model_step(k);
            if (!rst && ena) e_cnt++;
            @(posedge clk);
            #1;
            drive_inputs(cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
